axi_lite_mem_arbiter: RTL

Two-requester arbiter and sequencer that shares the single AXI-Lite memory/register slave of the cache-controller subsystem between the cache refill/writeback engine (port 0) and the debug/CPU-direct port (port 1). Each requester issues one word read or write on a simple req/done interface. The block grants one requester at a time with round-robin fairness and runs the complete AXI-Lite transaction as master. It returns read data and an error flag to the granted requester.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/axi_lite_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite memory arbiter: response codes and sequencer states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational; ptr names the port that wins a tie.
// Returns a one-hot grant, or 00 when nothing is requested.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ptr) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-Lite slave between two word requesters; done 3 cycles after grant with a zero-wait slave.
// AXI valids hold until handshake; requesters hold req until their one-cycle done pulse.
module axi_lite_mem_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_W-1:0]     r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  input  logic [DATA_W/8-1:0]   r0_wstrb,
  output logic                  r0_done,
  output logic [DATA_W-1:0]     r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_W-1:0]     r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  input  logic [DATA_W/8-1:0]   r1_wstrb,
  output logic                  r1_done,
  output logic [DATA_W-1:0]     r1_rdata,
  output logic                  r1_err,
  output logic [1:0]            gnt,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state, state_nxt;
  logic [1:0]          pick;
  logic                ptr;
  logic                owner;
  logic                aw_done, w_done;
  logic                aw_hs, w_hs;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [STRB_W-1:0]   pick_wstrb;
  logic                fin;
  logic                fin_err;
  logic [DATA_W-1:0]   fin_data;

  rr_arb2 u_arb (
    .req   ({r1_req, r0_req}),
    .ptr   (ptr),
    .grant (pick)
  );

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    pick_we    = r0_we;
    pick_addr  = r0_addr;
    pick_wdata = r0_wdata;
    pick_wstrb = r0_wstrb;
    if (pick[1]) begin
      pick_we    = r1_we;
      pick_addr  = r1_addr;
      pick_wdata = r1_wdata;
      pick_wstrb = r1_wstrb;
    end
  end

  // Reads return slave data; writes report zero data so a stale read never looks fresh.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    if (state == RD_DATA && rvalid) begin
      fin      = 1'b1;
      fin_err  = resp_t'(rresp) != OKAY;
      fin_data = rdata;
    end else if (state == WR_RESP && bvalid) begin
      fin      = 1'b1;
      fin_err  = resp_t'(bresp) != OKAY;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pick) state_nxt = pick_we ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arvalid && arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = DONE;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gnt      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      araddr   <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awaddr   <= '0;
      awvalid  <= 1'b0;
      wdata    <= '0;
      wstrb    <= '0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      r0_done  <= 1'b0;
      r0_rdata <= '0;
      r0_err   <= 1'b0;
      r1_done  <= 1'b0;
      r1_rdata <= '0;
      r1_err   <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        IDLE: if (|pick) begin
          gnt   <= pick;
          owner <= pick[1];
          if (pick_we) begin
            awaddr  <= pick_addr;
            wdata   <= pick_wdata;
            wstrb   <= pick_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            araddr  <= pick_addr;
            arvalid <= 1'b1;
          end
        end
        RD_ADDR: if (arvalid && arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        RD_DATA: if (rvalid) rready <= 1'b0;
        WR_REQ: begin
          // AW and W retire independently; either order or both together is fine.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (state_nxt == WR_RESP) bready <= 1'b1;
        end
        WR_RESP: if (bvalid) bready <= 1'b0;
        DONE: begin
          gnt <= '0;
          ptr <= ~owner;
        end
        default: ;
      endcase
      if (fin) begin
        if (owner) begin
          r1_done  <= 1'b1;
          r1_rdata <= fin_data;
          r1_err   <= fin_err;
        end else begin
          r0_done  <= 1'b1;
          r0_rdata <= fin_data;
          r0_err   <= fin_err;
        end
      end
    end
  end

endmodule
